// File: rtl/ofdm_pkg.sv
// rtl/ofdm_pkg.sv - shared OFDM constellation levels and default 64-QAM slicer thresholds
package ofdm_pkg;

  // Per-axis amplitude levels shared with the transmit mapper: odd multiples of 5056, outer level clipped to full scale
  localparam logic signed [15:0] QN7 = -16'sd32767;
  localparam logic signed [15:0] QN5 = -16'sd25280;
  localparam logic signed [15:0] QN3 = -16'sd15168;
  localparam logic signed [15:0] QN1 = -16'sd5056;
  localparam logic signed [15:0] QP1 = 16'sd5056;
  localparam logic signed [15:0] QP3 = 16'sd15168;
  localparam logic signed [15:0] QP5 = 16'sd25280;
  localparam logic signed [15:0] QP7 = 16'sd32767;

  localparam logic [15:0] T1_DEF = 16'h2780;
  localparam logic [15:0] T2_DEF = 16'h4F00;
  localparam logic [15:0] T3_DEF = 16'h7680;

  typedef logic [2:0] gray3_t;

endpackage

// File: rtl/qam64_axis_slice.sv
// rtl/qam64_axis_slice.sv - combinational 16-bit signed axis value to 3-bit Gray level
module qam64_axis_slice
  import ofdm_pkg::*;
#(
  parameter logic [15:0] T1 = T1_DEF,
  parameter logic [15:0] T2 = T2_DEF,
  parameter logic [15:0] T3 = T3_DEF
) (
  input  logic signed [15:0] x,
  output gray3_t             code
);

  localparam logic signed [15:0] P1 = T1;
  localparam logic signed [15:0] P2 = T2;
  localparam logic signed [15:0] P3 = T3;
  localparam logic signed [15:0] N1 = -P1;
  localparam logic signed [15:0] N2 = -P2;
  localparam logic signed [15:0] N3 = -P3;

  // Values landing exactly on a threshold belong to the upper region
  always_comb begin
    code = 3'b000;
    if (x >= P3)          code = 3'b001;
    else if (x >= P2)     code = 3'b101;
    else if (x >= P1)     code = 3'b111;
    else if (x >= 16'sd0) code = 3'b011;
    else if (x >= N1)     code = 3'b010;
    else if (x >= N2)     code = 3'b110;
    else if (x >= N3)     code = 3'b100;
    else                  code = 3'b000;
  end

endmodule

// File: rtl/qam64_demod.sv
// rtl/qam64_demod.sv - two-stage hard-decision 64-QAM demapper with stream back-pressure
module qam64_demod
  import ofdm_pkg::*;
#(
  parameter logic [15:0] T1    = T1_DEF,
  parameter logic [15:0] T2    = T2_DEF,
  parameter logic [15:0] T3    = T3_DEF,
  parameter int          CNT_W = 16
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic [31:0]      DAT_I,
  input  logic             CYC_I,
  input  logic             WE_I,
  input  logic             STB_I,
  output logic             ACK_O,
  output logic [5:0]       DAT_O,
  output logic             CYC_O,
  output logic             STB_O,
  output logic             WE_O,
  input  logic             ACK_I,
  output logic [CNT_W-1:0] SYM_CNT
);

  logic        ena;
  logic        stall;
  logic [31:0] d1;
  logic        v1;
  logic        v1_n;
  logic        stb_n;
  logic        cyc_d;
  gray3_t      re_code;
  gray3_t      im_code;

  assign ena   = CYC_I & STB_I & WE_I;
  assign stall = STB_O & ~ACK_I;
  assign ACK_O = ena & ~stall;
  assign WE_O  = STB_O;

  qam64_axis_slice #(.T1(T1), .T2(T2), .T3(T3)) u_slice_re (
    .x    (d1[15:0]),
    .code (re_code)
  );

  qam64_axis_slice #(.T1(T1), .T2(T2), .T3(T3)) u_slice_im (
    .x    (d1[31:16]),
    .code (im_code)
  );

  // Both stages advance together whenever the output is not blocked
  always_comb begin
    v1_n  = v1;
    stb_n = STB_O;
    if (!stall) begin
      v1_n  = ACK_O;
      stb_n = v1;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      d1      <= '0;
      v1      <= 1'b0;
      DAT_O   <= '0;
      STB_O   <= 1'b0;
      CYC_O   <= 1'b0;
      cyc_d   <= 1'b0;
      SYM_CNT <= '0;
    end else begin
      if (ACK_O) d1 <= DAT_I;
      v1    <= v1_n;
      STB_O <= stb_n;
      if (!stall) DAT_O <= {im_code, re_code};
      cyc_d <= CYC_I;
      // Frame stays open until the last in-flight symbol has been handed off
      CYC_O <= CYC_I | v1_n | stb_n;
      if (CYC_I && !cyc_d)      SYM_CNT <= '0;
      else if (STB_O && ACK_I)  SYM_CNT <= SYM_CNT + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_qam64_demod.sv
// tb/tb_qam64_demod.sv - self-checking bench for qam64_demod
module tb_qam64_demod;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b1;
  logic [31:0] DAT_I = '0;
  logic        CYC_I = 1'b0;
  logic        WE_I  = 1'b0;
  logic        STB_I = 1'b0;
  logic        ACK_I = 1'b1;
  logic        ACK_O;
  logic [5:0]  DAT_O;
  logic        CYC_O;
  logic        STB_O;
  logic        WE_O;
  logic [15:0] SYM_CNT;

  logic        ack_o4;
  logic [5:0]  dat_o4;
  logic        cyc_o4;
  logic        stb_o4;
  logic        we_o4;
  logic [3:0]  sym_cnt4;

  qam64_demod dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(DAT_I), .CYC_I(CYC_I), .WE_I(WE_I), .STB_I(STB_I),
    .ACK_O(ACK_O), .DAT_O(DAT_O), .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ACK_I(ACK_I),
    .SYM_CNT(SYM_CNT)
  );

  qam64_demod #(.CNT_W(4)) dut4 (
    .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(DAT_I), .CYC_I(CYC_I), .WE_I(WE_I), .STB_I(STB_I),
    .ACK_O(ack_o4), .DAT_O(dat_o4), .CYC_O(cyc_o4), .STB_O(stb_o4), .WE_O(we_o4), .ACK_I(ACK_I),
    .SYM_CNT(sym_cnt4)
  );

  always #5 CLK_I = ~CLK_I;

  int n_checks = 0;
  int n_fail   = 0;

  int         thr  [0:6] = '{-30336, -20224, -10112, 0, 10112, 20224, 30336};
  logic [2:0] gray [0:7] = '{3'b000, 3'b100, 3'b110, 3'b010, 3'b011, 3'b111, 3'b101, 3'b001};

  logic [31:0] fdata [0:127];
  logic [5:0]  cap [$];

  logic        m_stb = 1'b0;
  logic        m_pv = 1'b0;
  logic        m_cyc = 1'b0;
  logic        m_cyc_prev = 1'b0;
  logic [31:0] m_px = '0;
  logic [5:0]  m_sym = '0;
  int          m_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Level index = number of thresholds at or below the value
  function automatic logic [2:0] lvl(input logic [15:0] v);
    int s;
    int k;
    s = int'($signed(v));
    k = 0;
    for (int j = 0; j < 7; j++) if (s >= thr[j]) k++;
    return gray[k];
  endfunction

  function automatic logic [5:0] sym_of(input logic [31:0] d);
    return {lvl(d[31:16]), lvl(d[15:0])};
  endfunction

  function automatic logic [15:0] rnd_val();
    int t;
    case ($urandom_range(0, 3))
      0, 1: return 16'($urandom);
      2: begin
        t = thr[$urandom_range(0, 6)] + int'($urandom_range(0, 2)) - 1;
        return t[15:0];
      end
      default: return 16'h8000;
    endcase
  endfunction

  task automatic model_reset();
    m_stb = 1'b0; m_pv = 1'b0; m_cyc = 1'b0; m_cyc_prev = 1'b0;
    m_px = '0; m_sym = '0; m_cnt = 0;
  endtask

  task automatic model_step();
    logic blocked;
    logic taken;
    blocked = m_stb && !ACK_I;
    taken   = CYC_I && STB_I && WE_I && !blocked;
    if (CYC_I && !m_cyc_prev) m_cnt = 0;
    else if (m_stb && ACK_I)  m_cnt = m_cnt + 1;
    if (!blocked) begin
      m_stb = m_pv;
      m_sym = sym_of(m_px);
      m_pv  = taken;
      if (taken) m_px = DAT_I;
    end
    m_cyc      = CYC_I || m_pv || m_stb;
    m_cyc_prev = CYC_I;
  endtask

  initial begin
    forever begin
      @(posedge CLK_I or posedge RST_I);
      if (RST_I) model_reset();
      else model_step();
    end
  end

  initial begin
    logic exp_ack;
    forever begin
      @(negedge CLK_I);
      if (RST_I) model_reset();
      exp_ack = CYC_I && STB_I && WE_I && !(m_stb && !ACK_I);
      check("ack_o", ACK_O, exp_ack);
      check("stb_o", STB_O, m_stb);
      check("we_o", WE_O, m_stb);
      check("cyc_o", CYC_O, m_cyc);
      check("sym_cnt", SYM_CNT, m_cnt % 65536);
      check("sym_cnt4", sym_cnt4, m_cnt % 16);
      if (m_stb) check("dat_o", DAT_O, m_sym);
    end
  end

  initial begin
    forever begin
      @(negedge CLK_I);
      if (!RST_I && STB_O && ACK_I) cap.push_back(DAT_O);
    end
  end

  task automatic run_frame(input int n, input bit rnd, input int bp_at);
    int  i;
    int  cyc;
    bit  take;
    bit  in_bp;
    i = 0;
    cyc = 0;
    cap.delete();
    @(posedge CLK_I); #1;
    CYC_I = 1'b1;
    while (i < n && cyc < 4000) begin
      STB_I = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      WE_I  = rnd ? ($urandom_range(0, 5) != 0) : 1'b1;
      DAT_I = fdata[i];
      ACK_I = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_bp = (bp_at >= 0) && (cyc >= bp_at) && (cyc < bp_at + 3);
      if (in_bp) ACK_I = 1'b0;
      @(negedge CLK_I);
      take = ACK_O;
      if (in_bp) check("bp_ack_low", ACK_O, 1'b0);
      @(posedge CLK_I); #1;
      if (take) i++;
      cyc++;
    end
    check("accepted", i, n);
    CYC_I = 1'b0;
    STB_I = 1'b0;
    WE_I  = 1'b0;
    cyc = 0;
    while (cyc < 400) begin
      ACK_I = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge CLK_I);
      if (!CYC_O) break;
      @(posedge CLK_I); #1;
      cyc++;
    end
    check("drained", CYC_O, 1'b0);
    check("captured", cap.size(), n);
    ACK_I = 1'b1;
  endtask

  task automatic check_sequence(input int n);
    for (int j = 0; j < n && j < cap.size(); j++) check("seq", cap[j], sym_of(fdata[j]));
  endtask

  logic [15:0] edge_re  [0:6] = '{16'h0000, 16'hFFFF, 16'h2780, 16'h277F, 16'hD880, 16'h7680, 16'h8000};
  logic [2:0]  edge_exp [0:6] = '{3'b011, 3'b010, 3'b111, 3'b011, 3'b010, 3'b001, 3'b000};
  logic [15:0] q_lvl    [0:7] = '{16'h8001, 16'h9D40, 16'hC4C0, 16'hEC40, 16'h13C0, 16'h3B40, 16'h62C0, 16'h7FFF};

  initial begin
    int n;
    logic [15:0] held;

    check("model_pin_0", lvl(16'h0000), 3'b011);
    check("model_pin_ffff", lvl(16'hFFFF), 3'b010);
    check("model_pin_t1", lvl(16'h2780), 3'b111);
    check("model_pin_neg_t3", lvl(16'h8980), 3'b100);
    check("model_pin_min", lvl(16'h8000), 3'b000);

    #3;
    check("rst_stb_o", STB_O, 1'b0);
    check("rst_cyc_o", CYC_O, 1'b0);
    check("rst_dat_o", DAT_O, 6'd0);
    check("rst_sym_cnt", SYM_CNT, 16'd0);
    @(posedge CLK_I); #1;
    RST_I = 1'b0;

    for (int k = 0; k < 7; k++) fdata[k] = {16'h0000, edge_re[k]};
    run_frame(7, 1'b0, -1);
    for (int k = 0; k < 7 && k < cap.size(); k++) check("edge_re", cap[k], {3'b011, edge_exp[k]});

    for (int k = 0; k < 64; k++) fdata[k] = {q_lvl[k / 8], q_lvl[k % 8]};
    fdata[0] = {16'h8001, 16'h7FFF};
    run_frame(64, 1'b0, -1);
    if (cap.size() > 0) check("ideal_first", cap[0], 6'b000001);
    for (int k = 1; k < 64 && k < cap.size(); k++)
      check("ideal_rt", cap[k], {gray[k / 8], gray[k % 8]});
    check("ideal_cnt", SYM_CNT, 16'd64);
    check("ideal_cnt4", sym_cnt4, 4'd0);

    for (int k = 0; k < 20; k++) fdata[k] = {rnd_val(), rnd_val()};
    run_frame(20, 1'b0, 8);
    check_sequence(20);
    held = SYM_CNT;
    check("bp_cnt", held, 16'd20);
    repeat (5) @(posedge CLK_I);
    #1;
    check("cnt_hold", SYM_CNT, 16'd20);

    for (int k = 0; k < 18; k++) fdata[k] = {rnd_val(), rnd_val()};
    run_frame(18, 1'b1, -1);
    check_sequence(18);
    check("wrap_cnt4", sym_cnt4, 4'd2);
    check("wrap_cnt16", SYM_CNT, 16'd18);

    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, 40);
      for (int k = 0; k < n; k++) fdata[k] = {rnd_val(), rnd_val()};
      run_frame(n, 1'b1, -1);
      check_sequence(n);
      check("rand_cnt", SYM_CNT, n);
    end

    @(posedge CLK_I); #1;
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ACK_I = 1'b1;
    for (int k = 0; k < 6; k++) begin
      DAT_I = {16'h7FFF, 16'h7FFF};
      @(posedge CLK_I); #1;
    end
    ACK_I = 1'b0;
    repeat (2) begin
      @(posedge CLK_I); #1;
    end
    @(negedge CLK_I); #2;
    RST_I = 1'b1;
    #1;
    check("arst_stb_o", STB_O, 1'b0);
    check("arst_cyc_o", CYC_O, 1'b0);
    check("arst_dat_o", DAT_O, 6'd0);
    check("arst_sym_cnt", SYM_CNT, 16'd0);
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; ACK_I = 1'b1;
    @(posedge CLK_I); #1;
    RST_I = 1'b0;
    for (int k = 0; k < 5; k++) fdata[k] = {rnd_val(), rnd_val()};
    run_frame(5, 1'b0, -1);
    check_sequence(5);
    check("post_rst_cnt", SYM_CNT, 16'd5);

    repeat (3) @(posedge CLK_I);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
